// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Byte-serial RAM sequencer for icache fetches and LSU accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        inst_require_i,
    input  logic [31:0] inst_addr_i,
    output logic        inst_busy_o,
    output logic        inst_enable_o,
    output logic [31:0] inst_data_o,
    input  logic        mem_require_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_len_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_busy_o,
    output logic        mem_enable_o,
    output logic [31:0] mem_rdata_o,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [2:0]  nbytes, nbytes_nx;
    logic        is_mem, is_mem_nx;
    logic [31:0] addr, addr_nx;
    logic [31:0] wdata, wdata_nx;
    logic [31:0] asm_q, asm_nx;
    logic        busy, busy_nx;
    logic        inst_en, inst_en_nx;
    logic        mem_en, mem_en_nx;
    logic [31:0] inst_data, inst_data_nx;
    logic [31:0] mem_rdata, mem_rdata_nx;
    logic [31:0] ram_a_q, ram_a_nx;
    logic [7:0]  ram_dout_q, ram_dout_nx;
    logic        ram_wr_q, ram_wr_nx;
    logic [2:0]  cnt_inc;
    logic [1:0]  cap_sel;

    assign cnt_inc = cnt + 3'd1;
    // Byte arriving now belongs to the address driven one cycle earlier.
    assign cap_sel = cnt[1:0] - 2'd1;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        nbytes_nx    = nbytes;
        is_mem_nx    = is_mem;
        addr_nx      = addr;
        wdata_nx     = wdata;
        asm_nx       = asm_q;
        busy_nx      = busy;
        inst_en_nx   = 1'b0;
        mem_en_nx    = 1'b0;
        inst_data_nx = inst_data;
        mem_rdata_nx = mem_rdata;
        ram_a_nx     = ram_a_q;
        ram_dout_nx  = ram_dout_q;
        ram_wr_nx    = ram_wr_q;

        case (state)
            IDLE: begin
                if (mem_require_i) begin
                    is_mem_nx = 1'b1;
                    addr_nx   = mem_addr_i;
                    wdata_nx  = mem_wdata_i;
                    case (mem_len_i)
                        2'd0:    nbytes_nx = 3'd1;
                        2'd1:    nbytes_nx = 3'd2;
                        default: nbytes_nx = 3'd4;
                    endcase
                    state_nx  = mem_we_i ? WRITE : READ;
                    ram_a_nx  = mem_addr_i;
                    ram_wr_nx = mem_we_i;
                    if (mem_we_i) begin
                        ram_dout_nx = mem_wdata_i[7:0];
                    end
                end else if (inst_require_i) begin
                    is_mem_nx = 1'b0;
                    addr_nx   = inst_addr_i;
                    nbytes_nx = 3'd4;
                    state_nx  = READ;
                    ram_a_nx  = inst_addr_i;
                    ram_wr_nx = 1'b0;
                end
                if (mem_require_i || inst_require_i) begin
                    busy_nx = 1'b1;
                    cnt_nx  = 3'd0;
                    asm_nx  = 32'd0;
                end
            end
            READ: begin
                if (cnt != 3'd0) begin
                    asm_nx[{cap_sel, 3'b000} +: 8] = ram_din;
                end
                if (cnt == nbytes) begin
                    state_nx = IDLE;
                    cnt_nx   = 3'd0;
                    busy_nx  = 1'b0;
                    if (is_mem) begin
                        mem_en_nx    = 1'b1;
                        mem_rdata_nx = asm_nx;
                    end else begin
                        inst_en_nx   = 1'b1;
                        inst_data_nx = asm_nx;
                    end
                end else begin
                    cnt_nx   = cnt_inc;
                    ram_a_nx = (cnt_inc < nbytes) ? addr + {29'd0, cnt_inc} : 32'd0;
                end
            end
            WRITE: begin
                if (cnt_inc < nbytes) begin
                    cnt_nx      = cnt_inc;
                    ram_a_nx    = addr + {29'd0, cnt_inc};
                    ram_dout_nx = wdata[{cnt_inc[1:0], 3'b000} +: 8];
                    ram_wr_nx   = 1'b1;
                end else begin
                    state_nx  = IDLE;
                    cnt_nx    = 3'd0;
                    busy_nx   = 1'b0;
                    mem_en_nx = 1'b1;
                    ram_a_nx  = 32'd0;
                    ram_wr_nx = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            nbytes     <= 3'd0;
            is_mem     <= 1'b0;
            addr       <= 32'd0;
            wdata      <= 32'd0;
            asm_q      <= 32'd0;
            busy       <= 1'b0;
            inst_en    <= 1'b0;
            mem_en     <= 1'b0;
            inst_data  <= 32'd0;
            mem_rdata  <= 32'd0;
            ram_a_q    <= 32'd0;
            ram_dout_q <= 8'd0;
            ram_wr_q   <= 1'b0;
        end else if (rdy) begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            nbytes     <= nbytes_nx;
            is_mem     <= is_mem_nx;
            addr       <= addr_nx;
            wdata      <= wdata_nx;
            asm_q      <= asm_nx;
            busy       <= busy_nx;
            inst_en    <= inst_en_nx;
            mem_en     <= mem_en_nx;
            inst_data  <= inst_data_nx;
            mem_rdata  <= mem_rdata_nx;
            ram_a_q    <= ram_a_nx;
            ram_dout_q <= ram_dout_nx;
            ram_wr_q   <= ram_wr_nx;
        end
    end

    assign inst_busy_o   = busy;
    assign mem_busy_o    = busy;
    assign inst_enable_o = inst_en;
    assign mem_enable_o  = mem_en;
    assign inst_data_o   = inst_data;
    assign mem_rdata_o   = mem_rdata;
    assign ram_a         = ram_a_q;
    assign ram_dout      = ram_dout_q;
    assign ram_wr        = ram_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Randomised scoreboard bench for mem_ctrl against a byte-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        inst_require_i, mem_require_i, mem_we_i;
    logic [31:0] inst_addr_i, mem_addr_i, mem_wdata_i;
    logic [1:0]  mem_len_i;
    logic        inst_busy_o, inst_enable_o, mem_busy_o, mem_enable_o, ram_wr;
    logic [31:0] inst_data_o, mem_rdata_o, ram_a;
    logic [7:0]  ram_din, ram_dout;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .inst_require_i(inst_require_i), .inst_addr_i(inst_addr_i),
        .inst_busy_o(inst_busy_o), .inst_enable_o(inst_enable_o), .inst_data_o(inst_data_o),
        .mem_require_i(mem_require_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_busy_o(mem_busy_o), .mem_enable_o(mem_enable_o), .mem_rdata_o(mem_rdata_o),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_mem; logic [31:0] data; int at; } exp_t;
    typedef struct { bit wr; logic [31:0] a; logic [7:0] d; } bus_t;

    exp_t        sbq[$];
    bus_t        bus_map [int];
    logic [7:0]  ram_m   [bit [31:0]];
    logic [7:0]  ref_mem [bit [31:0]];
    logic [7:0]  pre_m   [bit [31:0]];
    bit          skip_m  [bit [31:0]];
    int          cyc = 0, n_cmp = 0, n_bad = 0;
    int          busy_from = 1, busy_to = 0;
    bit          mon_en = 1'b0, bus_chk = 1'b0;
    logic [31:0] exp_last_mem = 32'd0;
    exp_t        mon_e;
    bus_t        mon_b;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] hinit(input bit [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] ram_rd(input bit [31:0] a);
        if (ram_m.exists(a)) return ram_m[a];
        if (pre_m.exists(a)) return pre_m[a];
        return hinit(a);
    endfunction
    function automatic logic [7:0] ref_rd(input bit [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        if (pre_m.exists(a)) return pre_m[a];
        return hinit(a);
    endfunction

    // The platform ready stalls the RAM as well, so data stays aligned across a freeze.
    always @(posedge clk) begin
        if (rdy) begin
            if (ram_wr === 1'b1) ram_m[ram_a] = ram_dout;
            ram_din <= ram_rd(ram_a);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected completion (cycle %0d)", nm, cyc);
    endtask

    task automatic accept_mem(input int t, input bit we, input logic [1:0] len,
                              input logic [31:0] a, input logic [31:0] wd, input int extra);
        int n;
        exp_t e;
        logic [31:0] d;
        n = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        d = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (we) ref_mem[32'(a + i)] = wd[8*i +: 8];
            else    d[8*i +: 8] = ref_rd(32'(a + i));
            if (bus_chk) bus_map[t + 1 + i] = '{we, 32'(a + i), we ? wd[8*i +: 8] : 8'h00};
        end
        e.is_mem = 1'b1;
        if (we) begin
            e.data = exp_last_mem;
            e.at   = t + n + 1 + extra;
        end else begin
            e.data       = d;
            exp_last_mem = d;
            e.at         = t + n + 2 + extra;
        end
        busy_from = t + 1;
        busy_to   = e.at - 1;
        sbq.push_back(e);
    endtask

    task automatic accept_inst(input int t, input logic [31:0] a, input int extra);
        exp_t e;
        e.data = 32'd0;
        for (int i = 0; i < 4; i++) begin
            e.data[8*i +: 8] = ref_rd(32'(a + i));
            if (bus_chk) bus_map[t + 1 + i] = '{1'b0, 32'(a + i), 8'h00};
        end
        e.is_mem  = 1'b0;
        e.at      = t + 6 + extra;
        busy_from = t + 1;
        busy_to   = e.at - 1;
        sbq.push_back(e);
    endtask

    // Called just after a rising edge; returns one cycle after the last acceptance.
    task automatic run_req(input bit di, input logic [31:0] ia, input bit dm, input bit we,
                           input logic [1:0] len, input logic [31:0] ma, input logic [31:0] wd,
                           input int extra);
        bit pi, pm;
        int guard;
        pi = di; pm = dm; guard = 0;
        while ((pi || pm) && guard < 200) begin
            mem_require_i  = pm && !mem_busy_o;
            inst_require_i = pi && !inst_busy_o;
            mem_we_i    = pm ? we  : 1'($urandom);
            mem_len_i   = pm ? len : 2'($urandom);
            mem_addr_i  = pm ? ma  : $urandom;
            mem_wdata_i = pm ? wd  : $urandom;
            inst_addr_i = pi ? ia  : $urandom;
            if (!mem_busy_o) begin
                if (pm) begin
                    accept_mem(cyc, we, len, ma, wd, extra);
                    pm = 1'b0;
                end else if (pi) begin
                    accept_inst(cyc, ia, extra);
                    pi = 1'b0;
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        mem_require_i  = 1'b0;
        inst_require_i = 1'b0;
        mem_addr_i     = $urandom;
        inst_addr_i    = $urandom;
        if (guard >= 200) fail_now("accept_timeout");
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sbq.size() != 0 || inst_busy_o) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) fail_now("drain_timeout");
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus_chk) begin
                chk("busy", 64'(mem_busy_o), 64'(cyc >= busy_from && cyc <= busy_to));
                if (bus_map.exists(cyc)) begin
                    mon_b = bus_map[cyc];
                    bus_map.delete(cyc);
                    chk("ram_a", 64'(ram_a), 64'(mon_b.a));
                    chk("ram_wr", 64'(ram_wr), 64'(mon_b.wr));
                    if (mon_b.wr) chk("ram_dout", 64'(ram_dout), 64'(mon_b.d));
                end else begin
                    chk("bus_idle", 64'({ram_wr, ram_a}), 64'd0);
                end
            end
            if (inst_enable_o || mem_enable_o) begin
                if (sbq.size() == 0) begin
                    chk("spurious_enable", 64'({inst_enable_o, mem_enable_o}), 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("enable_cycle", 64'(cyc), 64'(mon_e.at));
                    chk("enable_owner", 64'({inst_enable_o, mem_enable_o}),
                        mon_e.is_mem ? 64'd1 : 64'd2);
                    if (mon_e.is_mem) chk("mem_rdata", 64'(mem_rdata_o), 64'(mon_e.data));
                    else              chk("inst_data", 64'(inst_data_o), 64'(mon_e.data));
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int kind;
        rst = 1'b1; rdy = 1'b1;
        inst_require_i = 1'b0; mem_require_i = 1'b0; mem_we_i = 1'b0;
        inst_addr_i = 32'd0; mem_addr_i = 32'd0; mem_wdata_i = 32'd0; mem_len_i = 2'd0;
        pre_m[32'h100] = 8'h13; pre_m[32'h101] = 8'h05;
        pre_m[32'h102] = 8'h00; pre_m[32'h103] = 8'h00;
        pre_m[32'h40]  = 8'h80;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst_busy", 64'(inst_busy_o), 64'd0);
        chk("rst_mem_busy", 64'(mem_busy_o), 64'd0);
        chk("rst_enables", 64'({inst_enable_o, mem_enable_o}), 64'd0);
        chk("rst_inst_data", 64'(inst_data_o), 64'd0);
        chk("rst_mem_rdata", 64'(mem_rdata_o), 64'd0);
        chk("rst_ram_bus", 64'({ram_wr, ram_dout, ram_a}), 64'd0);
        rst = 1'b0;
        mon_en  = 1'b1;
        bus_chk = 1'b1;
        @(posedge clk); #1;

        // Directed: fetch, simultaneous requests, store, byte load, wrapping write.
        run_req(1'b1, 32'h100, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 0);
        drain();
        run_req(1'b1, 32'h100, 1'b1, 1'b0, 2'd2, 32'h200, 32'd0, 0);
        drain();
        run_req(1'b0, 32'd0, 1'b1, 1'b1, 2'd1, 32'h7FF, 32'hAABBCCDD, 0);
        drain();
        run_req(1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 32'h40, 32'd0, 0);
        drain();
        run_req(1'b0, 32'd0, 1'b1, 1'b1, 2'd2, 32'hFFFFFFFE, 32'h11223344, 0);
        drain();
        run_req(1'b0, 32'd0, 1'b1, 1'b0, 2'd3, 32'hFFFFFFFE, 32'd0, 0);
        drain();

        for (int k = 0; k < 60; k++) begin
            kind = int'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                             : 32'h1000 + $urandom_range(0, 47);
            run_req(kind == 0 || kind == 2, 32'h1000 + $urandom_range(0, 47),
                    kind != 0, 1'($urandom), 2'($urandom), a, $urandom, 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        drain();

        // Freeze for three cycles starting two cycles after a fetch is accepted.
        bus_chk = 1'b0;
        run_req(1'b1, 32'h1010, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 3);
        @(posedge clk); #1;
        rdy = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        drain();

        // Reset three cycles into a 4-byte write aborts it without a completion.
        mem_require_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'd2;
        mem_addr_i = 32'h3000; mem_wdata_i = $urandom;
        @(posedge clk); #1;
        mem_require_i = 1'b0;
        chk("abort_wr_started", 64'(ram_wr), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_busy_before", 64'(mem_busy_o), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ram_wr", 64'(ram_wr), 64'd0);
        chk("abort_busy", 64'(mem_busy_o), 64'd0);
        for (int i = 0; i < 4; i++) skip_m[32'h3000 + i] = 1'b1;
        exp_last_mem = 32'd0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        bus_chk   = 1'b1;
        busy_from = 1; busy_to = 0;
        run_req(1'b0, 32'd0, 1'b1, 1'b1, 2'd0, 32'h1005, 32'h000000A5, 0);
        drain();
        run_req(1'b1, 32'h1004, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 0);
        drain();

        foreach (ref_mem[x])
            if (!skip_m.exists(x)) chk("ram_content", 64'(ram_rd(x)), 64'(ref_mem[x]));
        foreach (ram_m[x])
            if (!skip_m.exists(x) && !ref_mem.exists(x))
                chk("ram_stray_write", 64'(ram_m[x]), 64'(ref_rd(x)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the fetch path and the byte-wide unified RAM. It serves two clients: the instruction cache (read-only, 32-bit words) and the load/store unit (1/2/4-byte reads and writes). It sequences each access as back-to-back byte cycles on the RAM port, assembles or splits little-endian words, and returns completion as a one-cycle enable pulse. It is the responding end of the icache `inst_require`/`inst_busy`/`inst_enable` handshake.

## Interface
- No parameters. Address width 32, RAM data width 8.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global ready; when low, every register holds its value.
- inst_require_i  in  1  icache fetch request; level, combinational on the icache side.
- inst_addr_i  in  32  fetch address.
- inst_busy_o  out  1  transaction in progress; the icache must not raise require while this is high.
- inst_enable_o  out  1  one-cycle pulse: inst_data_o valid.
- inst_data_o  out  32  fetched word, little-endian.
- mem_require_i  in  1  load/store request.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_len_i  in  2  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = treated as 4 B.
- mem_addr_i  in  32  byte address.
- mem_wdata_i  in  32  write data; low bytes are used.
- mem_busy_o  out  1  same value as inst_busy_o.
- mem_enable_o  out  1  one-cycle pulse: load/store complete.
- mem_rdata_o  out  32  load data, zero-extended.
- ram_din  in  8  RAM read data; valid one cycle after its address.
- ram_dout  out  8  RAM write data, registered.
- ram_a  out  32  RAM address, registered.
- ram_wr  out  1  RAM write strobe, registered.

## Operation
- **States:** IDLE, READ, WRITE. A byte counter cnt (0..4) and a latched request record (client, addr, n = byte count, wdata).
- **Accept:** in IDLE with rdy high, a request is accepted on the clock edge.
  - If mem_require_i is high, the load/store request is accepted (data priority).
  - Otherwise, if inst_require_i is high, the fetch is accepted with n = 4 and we = 0.
  - A request that is not accepted is not stored. The client re-requests after busy drops.
- **On accept:** busy goes to 1, cnt goes to 0, and the state goes to READ or WRITE.
- **READ:**
  - While cnt < n, drive ram_a = addr + cnt, ram_wr = 0.
  - When cnt ≥ 1, capture ram_din into byte cnt−1 of the assembly register.
  - At cnt = n, capture the last byte, drive ram_a = 0, pulse the owning client's enable, clear busy, and return to IDLE.
  - Unfilled upper bytes are 0.
- **WRITE:**
  - While cnt < n, drive ram_a = addr + cnt, ram_wr = 1, ram_dout = wdata[8·cnt+7 : 8·cnt].
  - At cnt = n, drive ram_wr = 0, pulse mem_enable_o, clear busy, and return to IDLE.
- **Address arithmetic:** addr + cnt is 32-bit and wraps modulo 2^32 (0xFFFFFFFF + 1 = 0x00000000).
- **Enable routing:** only the owning client's enable pulses. inst_data_o and mem_rdata_o hold their last value until the next completion for that client.
- **Request hold:** request inputs are ignored while not in IDLE. Changes mid-transaction have no effect.
- **rdy low:** state, cnt, and all registered outputs freeze, including enable pulses and ram_wr. A frozen ram_wr = 1 rewrites the same byte, which is harmless.
- **Reset:** aborts any transaction. No enable pulse is generated for it.

## Timing
- **Reset values:** state = IDLE, cnt = 0. busy = 0, both enables = 0, both data outputs = 0, ram_a = 0, ram_dout = 0, ram_wr = 0.
- **Timeline:** let T be the accept cycle.
  - ram_a = addr in cycle T+1.
  - Read of n bytes: enable is high in cycle T+n+2. 4-byte read → T+6; 1-byte read → T+3.
  - Write of n bytes: enable is high in cycle T+n+1. 4-byte write → T+5.
- **Busy window:** busy is high from T+1 through the cycle before the enable cycle. It is low in the enable cycle.
- **Back-to-back:** a new request is accepted in the enable cycle itself, giving zero dead cycles between transactions.
- **Throughput:** one RAM byte per cycle. The RAM bus is idle (ram_wr = 0, ram_a = 0) in IDLE and in the final READ cycle.

## Test plan
- **Reset check:** rst high for 2 cycles → every output is 0.
- **Fetch:** RAM[0x100..0x103] = 13 05 00 00, inst_require_i = 1, addr 0x100 at T.
  - ram_a = 0x100..0x103 in T+1..T+4.
  - inst_enable_o = 1 only in T+6, with inst_data_o = 0x00000513.
  - mem_enable_o stays 0.
- **Simultaneous requests:** inst and mem (4-byte read of 0x200) both requested at T → data served first, mem_enable_o at T+6. The fetch is accepted at T+6 when the icache re-requests, with inst_enable_o at T+12.
- **Store:** 2-byte write, wdata = 0xAABBCCDD, addr 0x7FF at T.
  - ram_wr = 1 with ram_a/ram_dout = 0x7FF/DD in T+1 and 0x800/CC in T+2.
  - mem_enable_o at T+3, and no write of AA or BB.
- **Byte load and wrap:** 1-byte load at 0x40 with RAM byte 0x80 → mem_rdata_o = 0x00000080 at T+3. A 4-byte write at 0xFFFFFFFE → ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- **Stall and abort:** rdy low for 3 cycles starting at T+2 of a fetch → inst_enable_o moves to T+9 and data is unchanged. rst asserted at T+3 of a write → ram_wr = 0 and busy = 0 next cycle, with no enable pulse.
